nvdla_nocif_arb_cfg_regfile: RTL and testbench
==============================================

# nvdla_nocif_arb_cfg_regfile

Parametrised configuration register file for the NOCIF read/write arbiters, serving both the MCIF and CVIF instances. It decodes CSB-style requests with a valid/ready handshake and returns registered responses under backpressure. Weight and outstanding-count fields are staged in shadow registers and transferred to the arbiter-facing outputs only on a software commit while the interface is idle. Software-error conditions are recorded in sticky, write-1-to-clear status bits.

## Interface
Parameters:
- NUM_RD_CLIENTS, default 12: read clients. Range 1..16.
- NUM_WR_CLIENTS, default 8: write clients. Range 1..16.
- WEIGHT_RST, default 8'h01: reset value of every weight field.
- OS_CNT_RST, default 8'hFF: reset value of both outstanding counts.

Ports (name, direction, width, meaning):
- nvdla_core_clk, in, 1: the single clock.
- nvdla_core_rstn, in, 1: reset; **asynchronous, active-low**.
- req_pvld, in, 1: request valid.
- req_prdy, out, 1: request ready.
- req_addr, in, 12: byte offset within the 4 KB window; bits [1:0] are ignored.
- req_write, in, 1: 1 = write, 0 = read.
- req_wdat, in, 32: write data.
- rsp_valid, out, 1: response valid.
- rsp_prdy, in, 1: response ready.
- rsp_rdat, out, 32: read data; 0 for writes.
- rsp_err, out, 1: request hit an undefined or read-only address.
- rd_weight, out, 8*NUM_RD_CLIENTS: active read weights; client i occupies [8i+7:8i].
- wr_weight, out, 8*NUM_WR_CLIENTS: active write weights.
- rd_os_cnt, out, 8: active read outstanding limit.
- wr_os_cnt, out, 8: active write outstanding limit.
- idle, in, 1: arbiters have no traffic in flight.
- cfg_update, out, 1: one-cycle pulse on the cycle the active outputs change.

## Operation
Register map (offsets within the window):
- 0x000 + 4k: RD_WEIGHT_k, for k = 0..ceil(NUM_RD_CLIENTS/4)-1. Client 4k+j is in bits [8j+7:8j].
- 0x040 + 4k: WR_WEIGHT_k, same packing.
- 0x080: OS_CNT. [7:0] = rd, [15:8] = wr.
- 0x084: STATUS, read-only. [0] = commit_pending, [8] = live idle.
- 0x088: CONTROL. Writing [0]=1 requests a commit. Reads return 0.
- 0x08C: ERR, write-1-to-clear. [0] = invalid_wr, [1] = ro_wr, [2] = invalid_rd.

Decode and access rules:
- Byte lanes for clients at or beyond the client count are not stored and read 0. A register index beyond the client count is undefined.
- Reads of weight and OS_CNT registers return the shadow values, not the active values.
- A write to an undefined address is dropped, sets ERR[0] and returns rsp_err=1.
- A write to STATUS sets ERR[1] and returns rsp_err=1.
- A read of an undefined address returns 0, sets ERR[2] and returns rsp_err=1.

Commit mechanism:
- Writing CONTROL[0]=1 sets commit_pending.
- Transfer happens on any cycle where commit_pending=1 and idle=1. On that cycle, all shadow values are copied to the active outputs, commit_pending clears, and cfg_update pulses.
- Active outputs never change on any other cycle.
- A commit write while commit_pending=1 has no additional effect.
- Shadow writes while commit_pending=1 are accepted. The transfer uses the shadow values present on the transfer cycle.

ERR register:
- On a simultaneous set and W1C of the same bit, set wins.

Reset:
- Shadow and active weights reset to WEIGHT_RST; shadow and active OS counts reset to OS_CNT_RST.
- commit_pending, ERR, rsp_valid, rsp_err, rsp_rdat and cfg_update reset to 0.
- Asserting reset mid-commit discards the pending commit and any unreturned response.

## Timing
- req_prdy = !rsp_valid | rsp_prdy, combinational.
- A request is accepted when req_pvld & req_prdy. Register and ERR updates take effect at that clock edge.
- The response is registered: rsp_valid rises the cycle after acceptance and holds with stable rsp_rdat/rsp_err until rsp_prdy=1.
- Back-to-back accepts give back-to-back responses when rsp_prdy stays 1. Sustained throughput is 1 request per cycle.
- Commit latency: with idle=1, active outputs update and cfg_update pulses one cycle after the CONTROL write is accepted (the pending flag is registered first). With idle=0, the transfer occurs on the first cycle idle=1.
- A read of STATUS in the same cycle as a transfer returns the pre-transfer commit_pending value (1).

## Test plan
- **Reset defaults:** release reset with defaults. Expect rd_weight all 8'h01, rd_os_cnt=wr_os_cnt=8'hFF, and reading 0x080 returns 32'h0000FFFF.
- **Shadow isolation:** write 0x000 ← 32'h04030201 with idle=0. Expect a readback of 32'h04030201, rd_weight[31:0] still 32'h01010101, and STATUS[0]=0.
- **Commit gated by idle:** after the shadow write above, write CONTROL ← 1 with idle=0 for 10 cycles, then raise idle. Expect STATUS[0]=1 throughout. On the first idle=1 cycle, expect rd_weight[31:0]=32'h04030201 and a single cfg_update pulse.
- **Errors and W1C:** with NUM_RD_CLIENTS=12, write 0x00C (an undefined index), then write 0x084. Expect rsp_err=1 on both and ERR=3'b011. Then write ERR ← 32'h1. Expect ERR=3'b010.
- **Backpressure:** issue 3 reads with rsp_prdy held 0. Expect the first accepted, req_prdy=0 afterwards, and the response held stable. Release rsp_prdy. Expect the remaining two to complete in order, one per cycle.
- **Reset mid-commit:** set commit_pending with idle=0, then pulse nvdla_core_rstn low. Expect outputs back at reset values, STATUS[0]=0, and no cfg_update pulse when idle later rises.

Source files
------------

// File: rtl/nvdla_nocif_arb_cfg_regfile.sv
// Configuration register file for the NOCIF read/write arbiters.
// Decodes CSB-style requests and stages weights and outstanding counts in shadow registers.
// Software commits the shadow values to the arbiter-facing outputs, and the transfer
// waits until the arbiters report idle.
module nvdla_nocif_arb_cfg_regfile #(
  parameter int unsigned NUM_RD_CLIENTS = 12,
  parameter int unsigned NUM_WR_CLIENTS = 8,
  parameter logic [7:0]  WEIGHT_RST     = 8'h01,
  parameter logic [7:0]  OS_CNT_RST     = 8'hFF
) (
  input  logic                          nvdla_core_clk,
  input  logic                          nvdla_core_rstn,
  input  logic                          req_pvld,
  output logic                          req_prdy,
  input  logic [11:0]                   req_addr,
  input  logic                          req_write,
  input  logic [31:0]                   req_wdat,
  output logic                          rsp_valid,
  input  logic                          rsp_prdy,
  output logic [31:0]                   rsp_rdat,
  output logic                          rsp_err,
  output logic [8*NUM_RD_CLIENTS-1:0]   rd_weight,
  output logic [8*NUM_WR_CLIENTS-1:0]   wr_weight,
  output logic [7:0]                    rd_os_cnt,
  output logic [7:0]                    wr_os_cnt,
  input  logic                          idle,
  output logic                          cfg_update
);

  localparam int unsigned NumRdRegs = (NUM_RD_CLIENTS + 3) / 4;
  localparam int unsigned NumWrRegs = (NUM_WR_CLIENTS + 3) / 4;

  logic [8*NUM_RD_CLIENTS-1:0] rd_shadow_q, rd_shadow_d, rd_weight_q, rd_weight_d;
  logic [8*NUM_WR_CLIENTS-1:0] wr_shadow_q, wr_shadow_d, wr_weight_q, wr_weight_d;
  logic [7:0]  rd_os_sh_q, rd_os_sh_d, wr_os_sh_q, wr_os_sh_d;
  logic [7:0]  rd_os_q, rd_os_d, wr_os_q, wr_os_d;
  logic        pending_q, pending_d;
  logic [2:0]  err_q, err_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, cfg_update_q, cfg_update_d;
  logic [31:0] rsp_rdat_q, rsp_rdat_d;

  logic        accept, wr_en, transfer;
  logic [9:0]  word;
  logic [3:0]  sub;
  logic        hit_rd, hit_wr, hit_os, hit_status, hit_ctrl, hit_err;
  logic        bad_acc, set_commit;
  logic [2:0]  err_set, err_clr;
  logic [31:0] rdat;
  logic        unused_addr;

  assign unused_addr = ^req_addr[1:0];

  assign req_prdy = !rsp_valid_q | rsp_prdy;
  assign accept   = req_pvld & req_prdy;
  assign wr_en    = accept & req_write;
  assign transfer = pending_q & idle;

  assign word       = req_addr[11:2];
  assign sub        = req_addr[5:2];
  assign hit_rd     = (word[9:4] == 6'd0) && (32'(sub) < NumRdRegs);
  assign hit_wr     = (word[9:4] == 6'd1) && (32'(sub) < NumWrRegs);
  assign hit_os     = (word == 10'h020);
  assign hit_status = (word == 10'h021);
  assign hit_ctrl   = (word == 10'h022);
  assign hit_err    = (word == 10'h023);

  // Address decode: read data, shadow writes and error classification
  always_comb begin
    rd_shadow_d = rd_shadow_q;
    wr_shadow_d = wr_shadow_q;
    rd_os_sh_d  = rd_os_sh_q;
    wr_os_sh_d  = wr_os_sh_q;
    rdat        = '0;
    bad_acc     = 1'b0;
    set_commit  = 1'b0;
    err_set     = 3'b000;
    err_clr     = 3'b000;
    if (hit_rd) begin
      // Only lanes of existing clients are matched, so the rest read 0 and drop writes
      for (int c = 0; c < int'(NUM_RD_CLIENTS); c++) begin
        if (int'(sub) == c / 4) begin
          rdat[8*(c%4) +: 8] = rd_shadow_q[8*c +: 8];
          if (wr_en) rd_shadow_d[8*c +: 8] = req_wdat[8*(c%4) +: 8];
        end
      end
    end else if (hit_wr) begin
      for (int c = 0; c < int'(NUM_WR_CLIENTS); c++) begin
        if (int'(sub) == c / 4) begin
          rdat[8*(c%4) +: 8] = wr_shadow_q[8*c +: 8];
          if (wr_en) wr_shadow_d[8*c +: 8] = req_wdat[8*(c%4) +: 8];
        end
      end
    end else if (hit_os) begin
      rdat = {16'h0000, wr_os_sh_q, rd_os_sh_q};
      if (wr_en) begin
        rd_os_sh_d = req_wdat[7:0];
        wr_os_sh_d = req_wdat[15:8];
      end
    end else if (hit_status) begin
      rdat = {23'h0, idle, 7'h0, pending_q};
      if (req_write) begin
        bad_acc    = 1'b1;
        err_set[1] = 1'b1;
      end
    end else if (hit_ctrl) begin
      set_commit = req_write & req_wdat[0];
    end else if (hit_err) begin
      rdat = {29'h0, err_q};
      if (req_write) err_clr = req_wdat[2:0];
    end else begin
      bad_acc = 1'b1;
      if (req_write) err_set[0] = 1'b1;
      else           err_set[2] = 1'b1;
    end
    if (req_write) rdat = '0;
  end

  // Commit, error and response next-state
  always_comb begin
    pending_d    = pending_q;
    err_d        = err_q;
    rd_weight_d  = rd_weight_q;
    wr_weight_d  = wr_weight_q;
    rd_os_d      = rd_os_q;
    wr_os_d      = wr_os_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdat_d   = rsp_rdat_q;
    rsp_err_d    = rsp_err_q;
    cfg_update_d = transfer;
    if (accept) begin
      // Set wins over a simultaneous clear
      err_d       = (err_q & ~err_clr) | err_set;
      rsp_valid_d = 1'b1;
      rsp_rdat_d  = rdat;
      rsp_err_d   = bad_acc;
      if (set_commit) pending_d = 1'b1;
    end else if (rsp_prdy) begin
      rsp_valid_d = 1'b0;
    end
    // Transfer uses the registered shadows; a commit write on this cycle is absorbed
    if (transfer) begin
      pending_d   = 1'b0;
      rd_weight_d = rd_shadow_q;
      wr_weight_d = wr_shadow_q;
      rd_os_d     = rd_os_sh_q;
      wr_os_d     = wr_os_sh_q;
    end
  end

  // State registers
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      rd_shadow_q  <= {NUM_RD_CLIENTS{WEIGHT_RST}};
      wr_shadow_q  <= {NUM_WR_CLIENTS{WEIGHT_RST}};
      rd_weight_q  <= {NUM_RD_CLIENTS{WEIGHT_RST}};
      wr_weight_q  <= {NUM_WR_CLIENTS{WEIGHT_RST}};
      rd_os_sh_q   <= OS_CNT_RST;
      wr_os_sh_q   <= OS_CNT_RST;
      rd_os_q      <= OS_CNT_RST;
      wr_os_q      <= OS_CNT_RST;
      pending_q    <= 1'b0;
      err_q        <= 3'b000;
      rsp_valid_q  <= 1'b0;
      rsp_rdat_q   <= '0;
      rsp_err_q    <= 1'b0;
      cfg_update_q <= 1'b0;
    end else begin
      rd_shadow_q  <= rd_shadow_d;
      wr_shadow_q  <= wr_shadow_d;
      rd_weight_q  <= rd_weight_d;
      wr_weight_q  <= wr_weight_d;
      rd_os_sh_q   <= rd_os_sh_d;
      wr_os_sh_q   <= wr_os_sh_d;
      rd_os_q      <= rd_os_d;
      wr_os_q      <= wr_os_d;
      pending_q    <= pending_d;
      err_q        <= err_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdat_q   <= rsp_rdat_d;
      rsp_err_q    <= rsp_err_d;
      cfg_update_q <= cfg_update_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdat   = rsp_rdat_q;
  assign rsp_err    = rsp_err_q;
  assign rd_weight  = rd_weight_q;
  assign wr_weight  = wr_weight_q;
  assign rd_os_cnt  = rd_os_q;
  assign wr_os_cnt  = wr_os_q;
  assign cfg_update = cfg_update_q;

endmodule

// File: tb/tb_nvdla_nocif_arb_cfg_regfile.sv
// Scoreboard bench for the NOCIF arbiter config register file.
// A register-map model predicts every response and the active outputs; a monitor
// checks responses independently of the stimulus.
module tb_nvdla_nocif_arb_cfg_regfile;
  localparam int NRD = 12;
  localparam int NWR = 8;

  logic clk = 1'b0, rstn = 1'b0;
  logic req_pvld = 1'b0, req_write = 1'b0, rsp_prdy = 1'b1, idle = 1'b1;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdat = '0;
  logic req_prdy, rsp_valid, rsp_err, cfg_update;
  logic [31:0] rsp_rdat;
  logic [8*NRD-1:0] rd_weight;
  logic [8*NWR-1:0] wr_weight;
  logic [7:0] rd_os_cnt, wr_os_cnt;

  nvdla_nocif_arb_cfg_regfile #(
    .NUM_RD_CLIENTS(NRD), .NUM_WR_CLIENTS(NWR), .WEIGHT_RST(8'h01), .OS_CNT_RST(8'hFF)
  ) dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .req_pvld(req_pvld), .req_prdy(req_prdy),
    .req_addr(req_addr), .req_write(req_write), .req_wdat(req_wdat), .rsp_valid(rsp_valid),
    .rsp_prdy(rsp_prdy), .rsp_rdat(rsp_rdat), .rsp_err(rsp_err), .rd_weight(rd_weight),
    .wr_weight(wr_weight), .rd_os_cnt(rd_os_cnt), .wr_os_cnt(wr_os_cnt), .idle(idle),
    .cfg_update(cfg_update)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [32:0] exp_q[$];

  // Reference model state
  logic [7:0] m_rd_sh[16], m_rd_act[16], m_wr_sh[16], m_wr_act[16];
  logic [7:0] m_rdos_sh, m_wros_sh, m_rdos_act, m_wros_act;
  bit m_pending, m_slot, m_upd, m_last_acc;
  bit [2:0] m_err;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 16; c++) begin
      m_rd_sh[c] = 8'h01; m_rd_act[c] = 8'h01; m_wr_sh[c] = 8'h01; m_wr_act[c] = 8'h01;
    end
    m_rdos_sh = 8'hFF; m_wros_sh = 8'hFF; m_rdos_act = 8'hFF; m_wros_act = 8'hFF;
    m_pending = 0; m_slot = 0; m_upd = 0; m_last_acc = 0; m_err = 3'b000;
    exp_q.delete();
  endtask

  function automatic logic [8*NRD-1:0] exp_rd();
    logic [8*NRD-1:0] v;
    for (int c = 0; c < NRD; c++) v[8*c +: 8] = m_rd_act[c];
    return v;
  endfunction

  function automatic logic [8*NWR-1:0] exp_wr();
    logic [8*NWR-1:0] v;
    for (int c = 0; c < NWR; c++) v[8*c +: 8] = m_wr_act[c];
    return v;
  endfunction

  // One register access against the map; returns {err, rdata}
  task automatic model_access(input bit w, input logic [11:0] a, input logic [31:0] d,
                              input bit idl, input bit pend_pre,
                              output logic [32:0] rsp, output bit sc);
    int off;
    logic [31:0] rd;
    bit e;
    off = int'(a) & 'hFFC;
    rd = '0; e = 0; sc = 0;
    if (off < 'h80) begin
      bit isw;
      int k, n;
      isw = (off >= 'h40);
      k = (off % 'h40) / 4;
      n = isw ? NWR : NRD;
      if (4 * k < n) begin
        for (int j = 0; j < 4; j++) begin
          int c;
          c = 4 * k + j;
          if (c < n) begin
            if (w) begin
              if (isw) m_wr_sh[c] = d[8*j +: 8];
              else     m_rd_sh[c] = d[8*j +: 8];
            end else begin
              rd[8*j +: 8] = isw ? m_wr_sh[c] : m_rd_sh[c];
            end
          end
        end
      end else begin
        e = 1;
        if (w) m_err[0] = 1'b1; else m_err[2] = 1'b1;
      end
    end else if (off == 'h80) begin
      if (w) begin m_rdos_sh = d[7:0]; m_wros_sh = d[15:8]; end
      else rd = {16'h0, m_wros_sh, m_rdos_sh};
    end else if (off == 'h84) begin
      if (w) begin e = 1; m_err[1] = 1'b1; end
      else rd = (idl ? 32'h100 : 32'h0) | (pend_pre ? 32'h1 : 32'h0);
    end else if (off == 'h88) begin
      if (w && d[0]) sc = 1;
    end else if (off == 'h8C) begin
      if (w) m_err = m_err & ~d[2:0];
      else rd = {29'h0, m_err};
    end else begin
      e = 1;
      if (w) m_err[0] = 1'b1; else m_err[2] = 1'b1;
    end
    if (w) rd = '0;
    rsp = {e, rd};
  endtask

  // Advance the model across one clock edge using the inputs held during that cycle
  task automatic model_edge();
    bit ready, acc, xfer, pend_pre, sc;
    logic [32:0] rsp;
    ready = !m_slot || rsp_prdy;
    acc = req_pvld && ready;
    pend_pre = m_pending;
    xfer = pend_pre && idle;
    if (xfer) begin
      for (int c = 0; c < 16; c++) begin m_rd_act[c] = m_rd_sh[c]; m_wr_act[c] = m_wr_sh[c]; end
      m_rdos_act = m_rdos_sh; m_wros_act = m_wros_sh;
    end
    sc = 0;
    if (acc) begin
      model_access(req_write, req_addr, req_wdat, idle, pend_pre, rsp, sc);
      exp_q.push_back(rsp);
    end
    if (sc) m_pending = 1;
    if (xfer) m_pending = 0;
    if (acc) m_slot = 1; else if (rsp_prdy) m_slot = 0;
    m_upd = xfer;
    m_last_acc = acc;
  endtask

  // Check outputs mid-cycle, then step the model at the edge
  task automatic tick();
    @(negedge clk);
    chk("req_prdy", req_prdy, !m_slot || rsp_prdy);
    chk("rsp_valid", rsp_valid, m_slot);
    chk("cfg_update", cfg_update, m_upd);
    chk("rd_weight", rd_weight, exp_rd());
    chk("wr_weight", wr_weight, exp_wr());
    chk("os_cnt", {rd_os_cnt, wr_os_cnt}, {m_rdos_act, m_wros_act});
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send(input bit w, input logic [11:0] a, input logic [31:0] d);
    req_pvld = 1; req_write = w; req_addr = a; req_wdat = d;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m_last_acc) begin req_pvld = 0; return; end
    end
    total++; bad++;
    $display("FAIL send_timeout: addr %0h never accepted", a);
    req_pvld = 0;
  endtask

  task automatic apply_reset();
    rstn = 0;
    model_reset();
    #20;
    rstn = 1;
  endtask

  // Response monitor: compare whatever the DUT presents against the queue head
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && rsp_valid) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 1'b0);
        else begin
          chk("rsp", {rsp_err, rsp_rdat}, exp_q[0]);
          if (rsp_prdy) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    #16;
    rstn = 1;
    // Reset defaults
    tick(); tick();
    send(0, 12'h080, 0);
    // Shadow isolation
    idle = 0;
    send(1, 12'h000, 32'h04030201);
    send(0, 12'h000, 0);
    send(0, 12'h084, 0);
    // Commit gated by idle
    send(1, 12'h088, 32'h1);
    repeat (10) send(0, 12'h084, 0);
    idle = 1;
    tick(); tick(); tick();
    send(0, 12'h084, 0);
    // Errors and W1C
    send(1, 12'h08C, 32'h7);
    send(1, 12'h00C, 32'hDEADBEEF);
    send(1, 12'h084, 32'h1);
    send(0, 12'h08C, 0);
    send(1, 12'h08C, 32'h1);
    send(0, 12'h08C, 0);
    send(0, 12'h048, 0);   // lanes beyond NWR read 0 (index 2 undefined for 8 clients)
    send(0, 12'h044, 0);
    send(0, 12'h100, 0);
    // Backpressure
    rsp_prdy = 0;
    req_pvld = 1; req_write = 0; req_addr = 12'h000;
    tick();
    req_addr = 12'h040;
    repeat (4) tick();
    rsp_prdy = 1;
    tick();
    req_addr = 12'h080;
    tick();
    req_pvld = 0;
    repeat (3) tick();
    // Reset mid-commit
    idle = 0;
    send(1, 12'h000, 32'h11223344);
    send(1, 12'h088, 32'h1);
    tick();
    apply_reset();
    idle = 1;
    repeat (3) tick();
    send(0, 12'h084, 0);
    send(0, 12'h000, 0);
    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      req_pvld  = ($urandom_range(0, 3) != 0);
      req_write = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) < 7) req_addr = 12'($urandom_range(0, 37) * 4);
      else                          req_addr = 12'($urandom);
      req_wdat  = $urandom;
      idle      = ($urandom_range(0, 9) < 6);
      rsp_prdy  = ($urandom_range(0, 3) != 0);
      tick();
    end
    // Drain
    req_pvld = 0; rsp_prdy = 1; idle = 1;
    repeat (4) tick();
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
